// File: rtl/flit_packetizer_pkg.sv
// Shared definitions for the flit packetizer: flit flag encodings, header
// field positions and the packetizer FSM state type.
package flit_packetizer_pkg;

    localparam int P_EAW     = 4;
    localparam int P_DSTPW   = 4;
    localparam int P_CW      = 1;
    localparam int P_WEIGHTW = 4;

    localparam logic [1:0] HDR_FLAG    = 2'b10;
    localparam logic [1:0] BODY_FLAG   = 2'b00;
    localparam logic [1:0] TAIL_FLAG   = 2'b01;
    localparam logic [1:0] SINGLE_FLAG = 2'b11;

    // Header payload layout, LSB first; the router header extraction uses the same offsets.
    localparam int SRC_LSB    = 0;
    localparam int SRC_MSB    = SRC_LSB + P_EAW - 1;
    localparam int DST_LSB    = SRC_MSB + 1;
    localparam int DST_MSB    = DST_LSB + P_EAW - 1;
    localparam int DSTP_LSB   = DST_MSB + 1;
    localparam int DSTP_MSB   = DSTP_LSB + P_DSTPW - 1;
    localparam int CLASS_LSB  = DSTP_MSB + 1;
    localparam int CLASS_MSB  = CLASS_LSB + P_CW - 1;
    localparam int WEIGHT_LSB = CLASS_MSB + 1;
    localparam int WEIGHT_MSB = WEIGHT_LSB + P_WEIGHTW - 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_BODY = 2'd2
    } state_t;

endpackage

// File: rtl/flit_packetizer_credit_counter_bank.sv
// Bank of per-VC saturating credit counters, each starting at the downstream
// buffer depth; reports which VCs currently hold at least one credit.
module credit_counter_bank #(
    parameter int V    = 4,
    parameter int B    = 4,
    parameter int CNTW = $clog2(B + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [V-1:0]      i_dec,
    input  logic [V-1:0]      i_inc,
    output logic [V-1:0]      o_nonzero,
    output logic [V*CNTW-1:0] o_count
);

    for (genvar v = 0; v < V; v++) begin : g_vc
        logic [CNTW-1:0] r_cnt;

        // A simultaneous send and return cancel out, so only the lone cases move the count.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt <= CNTW'(B);
            end else if (i_inc[v] && !i_dec[v] && (r_cnt != CNTW'(B))) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (i_dec[v] && !i_inc[v] && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end

        assign o_nonzero[v]              = (r_cnt != '0);
        assign o_count[v*CNTW +: CNTW]   = r_cnt;
    end

endmodule

// File: rtl/flit_packetizer.sv
// Network-interface injection stage: turns a packet request plus a payload
// stream into header/body/tail flits, gated by per-VC router credits.
module flit_packetizer
    import flit_packetizer_pkg::*;
#(
    parameter int V       = 4,
    parameter int B       = 4,
    parameter int Fpay    = 32,
    parameter int EAw     = P_EAW,
    parameter int DSTPw   = P_DSTPW,
    parameter int Cw      = P_CW,
    parameter int WEIGHTw = P_WEIGHTW,
    parameter int LENw    = 8,
    localparam int Fw     = Fpay + V + 2,
    localparam int CNTW   = $clog2(B + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [EAw-1:0]     req_src_addr,
    input  logic [EAw-1:0]     req_dst_addr,
    input  logic [DSTPw-1:0]   req_destport,
    input  logic [Cw-1:0]      req_class,
    input  logic [WEIGHTw-1:0] req_weight,
    input  logic [V-1:0]       req_vc,
    input  logic [LENw-1:0]    req_len,
    input  logic [Fpay-1:0]    data_in,
    input  logic               data_valid,
    output logic               data_ready,
    input  logic [V-1:0]       credit_in,
    output logic [Fw-1:0]      flit_out,
    output logic               flit_out_wr,
    output logic               busy
);

    state_t             r_state;
    logic [Fw-1:0]      r_flit;
    logic               r_wr;
    logic               r_req_ready;
    logic               r_busy;
    logic [LENw-1:0]    r_rem;

    logic [EAw-1:0]     r_src;
    logic [EAw-1:0]     r_dst;
    logic [DSTPw-1:0]   r_destport;
    logic [Cw-1:0]      r_class;
    logic [WEIGHTw-1:0] r_weight;
    logic [V-1:0]       r_vc;
    logic [LENw-1:0]    r_len;

    logic [V-1:0]       w_credit_nz;
    logic [V*CNTW-1:0]  w_credit_cnt;
    logic               w_vc_nz;
    logic               w_data_ready;
    logic               w_send;
    logic [V-1:0]       w_dec;
    logic [Fpay-1:0]    w_hdr_payload;

    assign w_vc_nz      = |(w_credit_nz & r_vc);
    assign w_data_ready = (r_state == ST_BODY) && w_vc_nz;
    assign w_send       = ((r_state == ST_HDR) && w_vc_nz) || (w_data_ready && data_valid);
    assign w_dec        = w_send ? r_vc : '0;

    always_comb begin
        w_hdr_payload                        = '0;
        w_hdr_payload[SRC_MSB:SRC_LSB]       = r_src;
        w_hdr_payload[DST_MSB:DST_LSB]       = r_dst;
        w_hdr_payload[DSTP_MSB:DSTP_LSB]     = r_destport;
        w_hdr_payload[CLASS_MSB:CLASS_LSB]   = r_class;
        w_hdr_payload[WEIGHT_MSB:WEIGHT_LSB] = r_weight;
    end

    credit_counter_bank #(
        .V    (V),
        .B    (B),
        .CNTW (CNTW)
    ) u_credit (
        .clk       (clk),
        .rst_n     (reset),
        .i_dec     (w_dec),
        .i_inc     (credit_in),
        .o_nonzero (w_credit_nz),
        .o_count   (w_credit_cnt)
    );

    // Request fields only matter once a packet is in flight, so they carry no reset.
    always_ff @(posedge clk) begin
        if ((r_state == ST_IDLE) && req_valid) begin
            r_src      <= req_src_addr;
            r_dst      <= req_dst_addr;
            r_destport <= req_destport;
            r_class    <= req_class;
            r_weight   <= req_weight;
            r_vc       <= req_vc;
            r_len      <= (req_len == '0) ? LENw'(1) : req_len;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_flit      <= '0;
            r_wr        <= 1'b0;
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_rem       <= '0;
        end else begin
            r_wr <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_state     <= ST_HDR;
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                    end
                end
                ST_HDR: begin
                    if (w_vc_nz) begin
                        r_wr <= 1'b1;
                        if (r_len == LENw'(1)) begin
                            r_flit      <= {SINGLE_FLAG, r_vc, w_hdr_payload};
                            r_state     <= ST_IDLE;
                            r_req_ready <= 1'b1;
                            r_busy      <= 1'b0;
                        end else begin
                            r_flit  <= {HDR_FLAG, r_vc, w_hdr_payload};
                            r_rem   <= r_len - LENw'(1);
                            r_state <= ST_BODY;
                        end
                    end
                end
                ST_BODY: begin
                    if (data_valid && w_data_ready) begin
                        r_wr  <= 1'b1;
                        r_rem <= r_rem - LENw'(1);
                        if (r_rem == LENw'(1)) begin
                            r_flit      <= {TAIL_FLAG, r_vc, data_in};
                            r_state     <= ST_IDLE;
                            r_req_ready <= 1'b1;
                            r_busy      <= 1'b0;
                        end else begin
                            r_flit <= {BODY_FLAG, r_vc, data_in};
                        end
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_req_ready <= 1'b1;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign flit_out    = r_flit;
    assign flit_out_wr = r_wr;
    assign req_ready   = r_req_ready;
    assign busy        = r_busy;
    assign data_ready  = w_data_ready;

endmodule

// File: tb/tb_flit_packetizer.sv
// Directed bench for flit_packetizer: a table of packets with hand-computed
// flits, plus sequences for credit stall, credit overlap and mid-packet reset.
module tb_flit_packetizer;

    localparam int V    = 4;
    localparam int FPAY = 32;
    localparam int FW   = FPAY + V + 2;
    localparam int CNTW = 3;

    logic            clk;
    logic            reset;
    logic            req_valid;
    logic            req_ready;
    logic [3:0]      req_src_addr;
    logic [3:0]      req_dst_addr;
    logic [3:0]      req_destport;
    logic [0:0]      req_class;
    logic [3:0]      req_weight;
    logic [V-1:0]    req_vc;
    logic [7:0]      req_len;
    logic [FPAY-1:0] data_in;
    logic            data_valid;
    logic            data_ready;
    logic [V-1:0]    credit_in;
    logic [FW-1:0]   flit_out;
    logic            flit_out_wr;
    logic            busy;

    flit_packetizer dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_src_addr (req_src_addr),
        .req_dst_addr (req_dst_addr),
        .req_destport (req_destport),
        .req_class    (req_class),
        .req_weight   (req_weight),
        .req_vc       (req_vc),
        .req_len      (req_len),
        .data_in      (data_in),
        .data_valid   (data_valid),
        .data_ready   (data_ready),
        .credit_in    (credit_in),
        .flit_out     (flit_out),
        .flit_out_wr  (flit_out_wr),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [FW-1:0] q_flit[$];
    int            q_cyc[$];
    always @(negedge clk) begin
        if (flit_out_wr === 1'b1) begin
            q_flit.push_back(flit_out);
            q_cyc.push_back(cyc);
        end
    end

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] words[16];
    int          k;

    typedef struct {
        logic [7:0]  len;
        logic [3:0]  vc;
        logic [3:0]  src;
        logic [3:0]  dst;
        logic [3:0]  dp;
        logic [0:0]  cls;
        logic [3:0]  wt;
        logic [95:0] d;
        int          n_exp;
        logic [7:0]  fl;
        logic [31:0] hdr;
    } vec_t;

    vec_t tbl[4];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [CNTW-1:0] cnt(input int v);
        return dut.w_credit_cnt[v*CNTW +: CNTW];
    endfunction

    function automatic int vc_idx(input logic [3:0] vc);
        for (int i = 0; i < 4; i++) if (vc[i]) return i;
        return 0;
    endfunction

    task automatic do_req(input logic [7:0] len, input logic [3:0] vc, input logic [3:0] src,
                          input logic [3:0] dst, input logic [3:0] dp, input logic [0:0] cls,
                          input logic [3:0] wt, output int acc);
        chk("req_ready_idle", 64'(req_ready), 64'd1);
        req_len = len; req_vc = vc; req_src_addr = src; req_dst_addr = dst;
        req_destport = dp; req_class = cls; req_weight = wt;
        req_valid = 1'b1;
        @(posedge clk); #1;
        acc = cyc;
        req_valid = 1'b0;
        // Garbage on the request bus must not disturb the in-flight packet.
        req_len = 8'hFF; req_vc = 4'hF; req_src_addr = 4'hE; req_dst_addr = 4'hE;
    endtask

    task automatic run_pkt(input int budget, output bit timeout);
        bit hs;
        data_valid = 1'b1;
        data_in    = words[k];
        timeout    = 1'b1;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            hs = data_ready;
            @(posedge clk); #1;
            if (hs) k++;
            data_in = words[k];
            if (!busy) begin
                timeout = 1'b0;
                break;
            end
        end
        data_valid = 1'b0;
        @(negedge clk); #1;
    endtask

    task automatic stream_n(input int n);
        bit hs;
        data_valid = 1'b1;
        data_in    = words[k];
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            hs = data_ready;
            @(posedge clk); #1;
            if (hs) k++;
            data_in = words[k];
        end
        data_valid = 1'b0;
        @(negedge clk); #1;
    endtask

    task automatic give_credit(input logic [3:0] vc, input int n);
        repeat (n) begin
            @(posedge clk); #1;
            credit_in = vc;
        end
        @(posedge clk); #1;
        credit_in = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  acc;
        bit  to;
        logic [31:0] pay;

        tbl[0] = '{len:8'd1, vc:4'b0010, src:4'd3, dst:4'd9, dp:4'd0, cls:1'b0, wt:4'd0,
                   d:96'h0, n_exp:1, fl:8'b00_00_00_11, hdr:32'h0000_0093};
        tbl[1] = '{len:8'd4, vc:4'b0001, src:4'd1, dst:4'd2, dp:4'd5, cls:1'b1, wt:4'd7,
                   d:{32'h0000_00A3, 32'h0000_00A2, 32'h0000_00A1}, n_exp:4,
                   fl:8'b01_00_00_10, hdr:32'h0000_F521};
        tbl[2] = '{len:8'd0, vc:4'b1000, src:4'hF, dst:4'h0, dp:4'hF, cls:1'b0, wt:4'hF,
                   d:96'h0, n_exp:1, fl:8'b00_00_00_11, hdr:32'h0001_EF0F};
        tbl[3] = '{len:8'd2, vc:4'b0100, src:4'd6, dst:4'hA, dp:4'd3, cls:1'b1, wt:4'd1,
                   d:{64'h0, 32'hDEAD_BEEF}, n_exp:2, fl:8'b00_00_01_10, hdr:32'h0000_33A6};

        reset = 1'b0; req_valid = 1'b0; req_src_addr = '0; req_dst_addr = '0;
        req_destport = '0; req_class = '0; req_weight = '0; req_vc = '0; req_len = '0;
        data_in = '0; data_valid = 1'b0; credit_in = '0;
        for (int i = 0; i < 16; i++) words[i] = 32'h0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_flit_out",    64'(flit_out),    64'd0);
        chk("rst_flit_out_wr", 64'(flit_out_wr), 64'd0);
        chk("rst_req_ready",   64'(req_ready),   64'd1);
        chk("rst_data_ready",  64'(data_ready),  64'd0);
        chk("rst_busy",        64'(busy),        64'd0);
        for (int v = 0; v < V; v++) chk("rst_credit", 64'(cnt(v)), 64'd4);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;

        // Table-driven packets with ample credit.
        for (int i = 0; i < 4; i++) begin
            q_flit.delete(); q_cyc.delete(); k = 0;
            for (int w = 0; w < 3; w++) words[w] = tbl[i].d[w*32 +: 32];
            do_req(tbl[i].len, tbl[i].vc, tbl[i].src, tbl[i].dst, tbl[i].dp,
                   tbl[i].cls, tbl[i].wt, acc);
            run_pkt(20, to);
            chk("pkt_timeout", 64'(to), 64'd0);
            chk("pkt_nflits", 64'(q_flit.size()), 64'(tbl[i].n_exp));
            for (int j = 0; j < tbl[i].n_exp && j < q_flit.size(); j++) begin
                pay = (j == 0) ? tbl[i].hdr : tbl[i].d[(j-1)*32 +: 32];
                chk("pkt_flit", 64'(q_flit[j]), 64'({tbl[i].fl[2*j +: 2], tbl[i].vc, pay}));
                chk("pkt_flit_cycle", 64'(q_cyc[j]), 64'(acc + 1 + j));
            end
            chk("pkt_credit_used", 64'(cnt(vc_idx(tbl[i].vc))), 64'(4 - tbl[i].n_exp));
            give_credit(tbl[i].vc, tbl[i].n_exp);
            chk("pkt_credit_back", 64'(cnt(vc_idx(tbl[i].vc))), 64'd4);
        end

        // Credit stall: 6-flit packet on VC0 with only 4 credits.
        q_flit.delete(); q_cyc.delete(); k = 0;
        for (int i = 0; i < 16; i++) words[i] = 32'h5000_0000 + i;
        do_req(8'd6, 4'b0001, 4'd2, 4'd4, 4'd1, 1'b0, 4'd3, acc);
        stream_n(10);
        chk("stall_nflits", 64'(q_flit.size()), 64'd4);
        if (q_flit.size() >= 4)
            chk("stall_last_flit", 64'(q_flit[3]), 64'({2'b00, 4'b0001, 32'h5000_0002}));
        chk("stall_data_ready", 64'(data_ready), 64'd0);
        chk("stall_credit", 64'(cnt(0)), 64'd0);
        chk("stall_busy", 64'(busy), 64'd1);
        give_credit(4'b0001, 1);
        stream_n(4);
        chk("release1_nflits", 64'(q_flit.size()), 64'd5);
        if (q_flit.size() >= 5)
            chk("release1_flit", 64'(q_flit[4]), 64'({2'b00, 4'b0001, 32'h5000_0003}));
        give_credit(4'b0001, 1);
        stream_n(4);
        chk("release2_nflits", 64'(q_flit.size()), 64'd6);
        if (q_flit.size() >= 6)
            chk("release2_tail", 64'(q_flit[5]), 64'({2'b01, 4'b0001, 32'h5000_0004}));
        chk("release2_busy", 64'(busy), 64'd0);
        give_credit(4'b0001, 4);
        chk("stall_credit_back", 64'(cnt(0)), 64'd4);

        // Credits returned on the sending VC every cycle keep the counter at B.
        q_flit.delete(); q_cyc.delete(); k = 0;
        credit_in = 4'b0100;
        do_req(8'd4, 4'b0100, 4'd1, 4'd1, 4'd1, 1'b0, 4'd1, acc);
        run_pkt(20, to);
        chk("overlap_timeout", 64'(to), 64'd0);
        chk("overlap_nflits", 64'(q_flit.size()), 64'd4);
        chk("overlap_credit", 64'(cnt(2)), 64'd4);
        credit_in = '0;
        give_credit(4'b1000, 1);
        chk("saturate_credit", 64'(cnt(3)), 64'd4);

        // Asynchronous reset after 2 of 5 flits.
        q_flit.delete(); q_cyc.delete(); k = 0;
        do_req(8'd5, 4'b0001, 4'd7, 4'd8, 4'd2, 1'b1, 4'd5, acc);
        stream_n(2);
        chk("pre_reset_nflits", 64'(q_flit.size()), 64'd2);
        reset = 1'b0;
        #1;
        chk("mid_reset_wr",        64'(flit_out_wr), 64'd0);
        chk("mid_reset_flit_out",  64'(flit_out),    64'd0);
        chk("mid_reset_busy",      64'(busy),        64'd0);
        chk("mid_reset_req_ready", 64'(req_ready),   64'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("post_reset_busy", 64'(busy), 64'd0);
        chk("post_reset_req_ready", 64'(req_ready), 64'd1);
        for (int v = 0; v < V; v++) chk("post_reset_credit", 64'(cnt(v)), 64'd4);
        chk("post_reset_no_flits", 64'(q_flit.size()), 64'd2);

        q_flit.delete(); q_cyc.delete(); k = 0;
        words[0] = 32'hCAFE_0001;
        do_req(8'd2, 4'b0010, 4'd3, 4'd5, 4'd0, 1'b0, 4'd0, acc);
        run_pkt(20, to);
        chk("after_reset_timeout", 64'(to), 64'd0);
        chk("after_reset_nflits", 64'(q_flit.size()), 64'd2);
        if (q_flit.size() >= 2) begin
            chk("after_reset_hdr",  64'(q_flit[0]), 64'({2'b10, 4'b0010, 32'h0000_0053}));
            chk("after_reset_tail", 64'(q_flit[1]), 64'({2'b01, 4'b0010, 32'hCAFE_0001}));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
